mm_minmax_hold: RTL and testbench
=================================

Name: mm_minmax_hold

Overview:
- Parametrised multi-channel min/max/peak-to-peak tracker with timed hold windows for the multimeter datapath.
- Sits after the ADC and filter stages, in parallel with the averaging and RMS stages.
- Tracks a running minimum, maximum and last value per channel. Optionally freezes the results once per hold window so the 7-segment display and UART show stable values.
- Its output feeds the result selection and BCD/UART path like any other result source.

Parameters:
- DATA_W, 12: sample width, unsigned.
- CH_NR, 2: number of input channels, ≥1.
- CH_W, $clog2(CH_NR) (min 1): channel select width.
- HOLD_W, 27: hold timer width.
- HOLD_CNT, 100_000_000: hold window length in clk cycles (1 s at 100 MHz). Must satisfy 2 ≤ HOLD_CNT < 2^HOLD_W.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous clear of all state.
- din_i  in  CH_NR*DATA_W  packed samples; channel k occupies [k*DATA_W +: DATA_W].
- din_update_i  in  CH_NR  per-channel one-cycle sample strobe.
- ch_sel_i  in  CH_W  output channel select.
- mode_i  in  2  output mode: 00 last value, 01 min, 10 max, 11 peak-to-peak.
- hold_en_i  in  1  0 = live tracking, 1 = windowed hold.
- dout_o  out  DATA_W  selected result.
- dout_valid_o  out  1  selected result is meaningful.
- dout_update_o  out  1  one-cycle pulse marking a new result.
- win_end_o  out  1  one-cycle pulse at each hold window end.

Behaviour:
- Reset (async) and clr_i (sync, highest priority) both do the following:
  - clear all per-channel accumulators (last, min, max, acc_valid);
  - clear all snapshots (snap_last, snap_min, snap_max, snap_valid);
  - set the timer to 0;
  - drive dout_o=0, dout_valid_o=0, dout_update_o=0, win_end_o=0.
- Accumulator update, per channel k, on din_update_i[k]:
  - last ← sample.
  - If acc_valid=0: min ← sample, max ← sample, acc_valid ← 1.
  - Otherwise: min ← min(min, sample), max ← max(max, sample), unsigned compare.
  - Channels update independently; simultaneous strobes on several channels are all accepted in the same cycle.
- Timer:
  - Counts 0..HOLD_CNT-1 while hold_en_i=1 and wraps to 0.
  - Held at 0 while hold_en_i=0.
  - win_end is asserted in the cycle where the count equals HOLD_CNT-1. win_end_o is that signal registered, i.e. one cycle later.
- Window end (internal win_end), for every channel:
  - The snapshot takes the accumulator value including any sample arriving in the same cycle: that sample belongs to the closing window.
  - snap_valid ← acc_valid (or that cycle's strobe).
  - acc_valid ← 0, so the next sample re-seeds min and max. last is not cleared.
  - A window with no samples gives snap_valid=0.
- hold_en_i 1→0: snapshots are retained but not shown; the output returns to live accumulators immediately.
- hold_en_i 0→1: accumulators are not cleared. The first window starts at timer 0.
- Output register (1-cycle latency, updated every cycle):
  - Source: accumulators of ch_sel_i when hold_en_i=0, snapshots of ch_sel_i when hold_en_i=1.
  - mode 00 → last; 01 → min; 10 → max; 11 → max-min, unsigned and never negative.
  - dout_valid_o = source valid flag. When the source is invalid, dout_o=0.
  - In mode 00, validity is acc_valid, or snap_valid when holding.
  - An out-of-range ch_sel_i (≥CH_NR) gives dout_o=0 and dout_valid_o=0.
- dout_update_o:
  - hold_en_i=0: pulses the cycle after din_update_i[ch_sel_i].
  - hold_en_i=1: pulses the cycle after win_end (coincident with win_end_o).
  - A change of ch_sel_i or mode_i alone does not pulse.
- No arithmetic overflow is possible: p2p ≤ 2^DATA_W-1 and no wider paths are needed.

Test Plan:
- Reset and first sample (CH_NR=2, DATA_W=12, hold off):
  - After reset → all outputs 0.
  - ch0 samples 0x100, 0x050, 0x200 with mode=11, sel=0 → dout_o 0x000, 0x0B0, 0x1B0.
  - Each value is valid=1, with dout_update_o one cycle after each strobe.
- Channel independence:
  - ch0 gets 0x300 and ch1 gets 0x010 in the same cycle, then ch1 gets 0xFFF.
  - sel=1, mode=01 → 0x010; mode=10 → 0xFFF.
  - sel=0, mode=01 → 0x300.
  - No dout_update_o on the mode/sel changes.
- Hold window (HOLD_CNT=16):
  - hold on, ch0 samples 0x010 and 0x400 in window 1, plus 0x800 in its last cycle.
  - win_end_o pulses at cycle 16; mode=10 → dout_o 0x800 and dout_update_o coincide with win_end_o.
  - Window 2 has a single sample 0x020 → mode 10 shows 0x020 (re-seeded).
- Empty window: hold on, no samples for 16 cycles → dout_valid_o=0, dout_o=0 after the window end.
- Clear mid-window: clr_i at timer 7 → everything zero, timer restarts, and the next win_end_o comes 16 cycles after clr_i deasserts.
- Async reset mid-operation: assert rst_n=0 between clock edges → outputs drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mm_minmax_hold.sv
// Per-channel running min/max/last tracker with optional timed hold windows that freeze snapshots for display.
// Latency: one clk from sample strobe (live) or window end (hold) to the registered output.
// Backpressure: none; every strobe is accepted, and all channels may strobe in the same cycle.
module mm_minmax_hold #(
    parameter int DATA_W   = 12,
    parameter int CH_NR    = 2,
    parameter int CH_W     = (CH_NR > 1) ? $clog2(CH_NR) : 1,
    parameter int HOLD_W   = 27,
    parameter int HOLD_CNT = 100_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic [CH_NR*DATA_W-1:0] din_i,
    input  logic [CH_NR-1:0]        din_update_i,
    input  logic [CH_W-1:0]         ch_sel_i,
    input  logic [1:0]              mode_i,
    input  logic                    hold_en_i,
    output logic [DATA_W-1:0]       dout_o,
    output logic                    dout_valid_o,
    output logic                    dout_update_o,
    output logic                    win_end_o
);

    localparam logic [HOLD_W-1:0] TIMER_LAST = HOLD_W'(HOLD_CNT - 1);

    // live accumulators
    logic [DATA_W-1:0] last_q [CH_NR];
    logic [DATA_W-1:0] last_d [CH_NR];
    logic [DATA_W-1:0] min_q  [CH_NR];
    logic [DATA_W-1:0] min_d  [CH_NR];
    logic [DATA_W-1:0] max_q  [CH_NR];
    logic [DATA_W-1:0] max_d  [CH_NR];
    logic [CH_NR-1:0]  acc_vld_q;
    logic [CH_NR-1:0]  acc_vld_d;

    // snapshots taken at each window end
    logic [DATA_W-1:0] snap_last_q [CH_NR];
    logic [DATA_W-1:0] snap_last_d [CH_NR];
    logic [DATA_W-1:0] snap_min_q  [CH_NR];
    logic [DATA_W-1:0] snap_min_d  [CH_NR];
    logic [DATA_W-1:0] snap_max_q  [CH_NR];
    logic [DATA_W-1:0] snap_max_d  [CH_NR];
    logic [CH_NR-1:0]  snap_vld_q;
    logic [CH_NR-1:0]  snap_vld_d;

    logic [HOLD_W-1:0] timer_q;
    logic [HOLD_W-1:0] timer_d;
    logic              win_end;
    logic              win_end_q;

    logic [DATA_W-1:0] sample [CH_NR];

    // output selection
    logic              sel_ok;
    logic [CH_W-1:0]   sel_idx;
    logic [DATA_W-1:0] src_last;
    logic [DATA_W-1:0] src_min;
    logic [DATA_W-1:0] src_max;
    logic              src_vld;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic              dout_valid_q;
    logic              dout_valid_d;
    logic              dout_update_q;
    logic              dout_update_d;

    // unpack the per-channel samples from the flat input bus
    always_comb begin
        for (int k = 0; k < CH_NR; k++) begin
            sample[k] = din_i[k*DATA_W +: DATA_W];
        end
    end

    // hold timer: free-runs 0..HOLD_CNT-1 while holding, parked at 0 otherwise
    always_comb begin
        win_end = hold_en_i && (timer_q == TIMER_LAST);
        timer_d = '0;
        if (hold_en_i && !win_end) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // accumulator update; a sample coinciding with window end belongs to the closing window
    always_comb begin
        for (int k = 0; k < CH_NR; k++) begin
            last_d[k]      = last_q[k];
            min_d[k]       = min_q[k];
            max_d[k]       = max_q[k];
            acc_vld_d[k]   = acc_vld_q[k];
            snap_last_d[k] = snap_last_q[k];
            snap_min_d[k]  = snap_min_q[k];
            snap_max_d[k]  = snap_max_q[k];
            snap_vld_d[k]  = snap_vld_q[k];
            if (din_update_i[k]) begin
                last_d[k] = sample[k];
                if (!acc_vld_q[k] || (sample[k] < min_q[k])) begin
                    min_d[k] = sample[k];
                end
                if (!acc_vld_q[k] || (sample[k] > max_q[k])) begin
                    max_d[k] = sample[k];
                end
                acc_vld_d[k] = 1'b1;
            end
            if (win_end) begin
                snap_last_d[k] = last_d[k];
                snap_min_d[k]  = min_d[k];
                snap_max_d[k]  = max_d[k];
                snap_vld_d[k]  = acc_vld_d[k];
                // next sample re-seeds min/max; last is kept
                acc_vld_d[k]   = 1'b0;
            end
        end
    end

    // next output value from the post-update source so the result tracks its strobe by one cycle
    always_comb begin
        sel_ok  = (int'(ch_sel_i) < CH_NR);
        sel_idx = sel_ok ? ch_sel_i : '0;
        if (hold_en_i) begin
            src_last = snap_last_d[sel_idx];
            src_min  = snap_min_d[sel_idx];
            src_max  = snap_max_d[sel_idx];
            src_vld  = snap_vld_d[sel_idx];
        end else begin
            src_last = last_d[sel_idx];
            src_min  = min_d[sel_idx];
            src_max  = max_d[sel_idx];
            src_vld  = acc_vld_d[sel_idx];
        end
        dout_valid_d = sel_ok && src_vld;
        case (mode_i)
            2'b00:   dout_d = src_last;
            2'b01:   dout_d = src_min;
            2'b10:   dout_d = src_max;
            default: dout_d = src_max - src_min;
        endcase
        if (!dout_valid_d) begin
            dout_d = '0;
        end
        if (hold_en_i) begin
            dout_update_d = win_end;
        end else begin
            dout_update_d = sel_ok && din_update_i[sel_idx];
        end
    end

    // accumulator, snapshot and timer state; clear has priority over everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH_NR; k++) begin
                last_q[k]      <= '0;
                min_q[k]       <= '0;
                max_q[k]       <= '0;
                snap_last_q[k] <= '0;
                snap_min_q[k]  <= '0;
                snap_max_q[k]  <= '0;
            end
            acc_vld_q  <= '0;
            snap_vld_q <= '0;
            timer_q    <= '0;
        end else if (clr_i) begin
            for (int k = 0; k < CH_NR; k++) begin
                last_q[k]      <= '0;
                min_q[k]       <= '0;
                max_q[k]       <= '0;
                snap_last_q[k] <= '0;
                snap_min_q[k]  <= '0;
                snap_max_q[k]  <= '0;
            end
            acc_vld_q  <= '0;
            snap_vld_q <= '0;
            timer_q    <= '0;
        end else begin
            for (int k = 0; k < CH_NR; k++) begin
                last_q[k]      <= last_d[k];
                min_q[k]       <= min_d[k];
                max_q[k]       <= max_d[k];
                snap_last_q[k] <= snap_last_d[k];
                snap_min_q[k]  <= snap_min_d[k];
                snap_max_q[k]  <= snap_max_d[k];
            end
            acc_vld_q  <= acc_vld_d;
            snap_vld_q <= snap_vld_d;
            timer_q    <= timer_d;
        end
    end

    // registered outputs, refreshed every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            dout_update_q <= 1'b0;
            win_end_q     <= 1'b0;
        end else if (clr_i) begin
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            dout_update_q <= 1'b0;
            win_end_q     <= 1'b0;
        end else begin
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            dout_update_q <= dout_update_d;
            win_end_q     <= win_end;
        end
    end

    assign dout_o        = dout_q;
    assign dout_valid_o  = dout_valid_q;
    assign dout_update_o = dout_update_q;
    assign win_end_o     = win_end_q;

endmodule

// File: tb/tb_mm_minmax_hold.sv
// Bench for mm_minmax_hold: directed vectors, a sample-list reference model checked every cycle,
// and literal expectations at the key points of each scenario.
module tb_mm_minmax_hold;

    localparam int DW = 12;
    localparam int CH = 2;
    localparam int HC = 16;

    typedef logic [DW-1:0] s_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_i = 1'b0;
    logic [CH*DW-1:0] din_i = '0;
    logic [CH-1:0] din_update_i = '0;
    logic [0:0]    ch_sel_i = '0;
    logic [1:0]    mode_i = 2'b00;
    logic          hold_en_i = 1'b0;
    logic [DW-1:0] dout_o;
    logic          dout_valid_o;
    logic          dout_update_o;
    logic          win_end_o;

    int n_tests = 0;
    int n_fail  = 0;

    mm_minmax_hold #(
        .DATA_W  (DW),
        .CH_NR   (CH),
        .CH_W    (1),
        .HOLD_W  (27),
        .HOLD_CNT(HC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr_i),
        .din_i        (din_i),
        .din_update_i (din_update_i),
        .ch_sel_i     (ch_sel_i),
        .mode_i       (mode_i),
        .hold_en_i    (hold_en_i),
        .dout_o       (dout_o),
        .dout_valid_o (dout_valid_o),
        .dout_update_o(dout_update_o),
        .win_end_o    (win_end_o)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel keeps the list of samples seen since its last window end;
    // min/max are recomputed from that list.
    s_t  wq [CH][$];
    s_t  m_last  [CH];
    s_t  m_slast [CH];
    s_t  m_smin  [CH];
    s_t  m_smax  [CH];
    bit  m_sv    [CH];
    int  held_cycles = 0;
    s_t  e_dout = '0;
    bit  e_vld = 1'b0;
    bit  e_upd = 1'b0;
    bit  e_we  = 1'b0;

    function automatic s_t list_min(input int ch);
        s_t r = '1;
        if (wq[ch].size() == 0) return '0;
        foreach (wq[ch][i]) if (wq[ch][i] < r) r = wq[ch][i];
        return r;
    endfunction

    function automatic s_t list_max(input int ch);
        s_t r = '0;
        foreach (wq[ch][i]) if (wq[ch][i] > r) r = wq[ch][i];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit we;
        bit sv;
        s_t mn, mx, ls;
        int sel;
        if (!rst_n || clr_i) begin
            for (int c = 0; c < CH; c++) begin
                wq[c].delete();
                m_last[c]  = '0;
                m_slast[c] = '0;
                m_smin[c]  = '0;
                m_smax[c]  = '0;
                m_sv[c]    = 1'b0;
            end
            held_cycles = 0;
            e_dout = '0;
            e_vld  = 1'b0;
            e_upd  = 1'b0;
            e_we   = 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (din_update_i[c]) begin
                    m_last[c] = din_i[c*DW +: DW];
                    wq[c].push_back(din_i[c*DW +: DW]);
                end
            end
            // a window closes on every HC-th consecutive held cycle
            we = hold_en_i && (held_cycles == HC - 1);
            held_cycles = (hold_en_i && !we) ? held_cycles + 1 : 0;
            if (we) begin
                for (int c = 0; c < CH; c++) begin
                    m_sv[c]    = (wq[c].size() > 0);
                    m_smin[c]  = list_min(c);
                    m_smax[c]  = list_max(c);
                    m_slast[c] = m_last[c];
                    wq[c].delete();
                end
            end
            sel = int'(ch_sel_i);
            if (hold_en_i) begin
                sv = m_sv[sel]; mn = m_smin[sel]; mx = m_smax[sel]; ls = m_slast[sel];
            end else begin
                sv = (wq[sel].size() > 0); mn = list_min(sel); mx = list_max(sel); ls = m_last[sel];
            end
            e_vld = sv;
            case (mode_i)
                2'b00:   e_dout = ls;
                2'b01:   e_dout = mn;
                2'b10:   e_dout = mx;
                default: e_dout = mx - mn;
            endcase
            if (!sv) e_dout = '0;
            e_upd = hold_en_i ? we : din_update_i[sel];
            e_we  = we;
        end
    end

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        cmp("model_dout",   32'(dout_o),        32'(e_dout));
        cmp("model_valid",  32'(dout_valid_o),  32'(e_vld));
        cmp("model_update", 32'(dout_update_o), 32'(e_upd));
        cmp("model_winend", 32'(win_end_o),     32'(e_we));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int ch, input s_t v);
        din_i[ch*DW +: DW] = v;
        din_update_i[ch]   = 1'b1;
        tick();
        din_update_i = '0;
    endtask

    task automatic lit(input string name, input s_t d, input bit v, input bit u);
        cmp({name, "_dout"},  32'(dout_o),        32'(d));
        cmp({name, "_valid"}, 32'(dout_valid_o),  32'(v));
        cmp({name, "_upd"},   32'(dout_update_o), 32'(u));
    endtask

    // one full hold window; smp_at is the cycle of a ch0 sample (-1 none), with an optional extra in the last cycle
    task automatic run_window(input int smp_at, input s_t v, input int last_at, input s_t lv);
        for (int j = 0; j < HC; j++) begin
            if (j == smp_at) begin
                din_i[DW-1:0] = v;
                din_update_i[0] = 1'b1;
            end
            if (j == last_at) begin
                din_i[DW-1:0] = lv;
                din_update_i[0] = 1'b1;
            end
            tick();
            din_update_i = '0;
        end
    endtask

    initial begin : stim
        int first;
        rst_n = 1'b0;
        tick();
        tick();
        lit("reset", 12'h000, 1'b0, 1'b0);
        cmp("reset_winend", 32'(win_end_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // first samples, peak-to-peak on ch0
        mode_i = 2'b11; ch_sel_i = 1'b0;
        strobe(0, 12'h100); lit("p2p_1", 12'h000, 1'b1, 1'b1);
        tick();             lit("p2p_idle", 12'h000, 1'b1, 1'b0);
        strobe(0, 12'h050); lit("p2p_2", 12'h0B0, 1'b1, 1'b1);
        strobe(0, 12'h200); lit("p2p_3", 12'h1B0, 1'b1, 1'b1);

        // channel independence
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        lit("clr", 12'h000, 1'b0, 1'b0);
        din_i = {12'h010, 12'h300};
        din_update_i = 2'b11;
        tick();
        din_update_i = '0;
        strobe(1, 12'hFFF);
        ch_sel_i = 1'b1; mode_i = 2'b01; tick(); lit("ch1_min", 12'h010, 1'b1, 1'b0);
        mode_i = 2'b10;                  tick(); lit("ch1_max", 12'hFFF, 1'b1, 1'b0);
        ch_sel_i = 1'b0; mode_i = 2'b01; tick(); lit("ch0_min", 12'h300, 1'b1, 1'b0);

        // hold windows on ch0, max
        mode_i = 2'b10; hold_en_i = 1'b1;
        tick();
        // that tick was the first held cycle; rewind the window bookkeeping by running the remaining 15
        for (int j = 1; j < HC; j++) begin
            if (j == 2)  begin din_i[DW-1:0] = 12'h010; din_update_i[0] = 1'b1; end
            if (j == 5)  begin din_i[DW-1:0] = 12'h400; din_update_i[0] = 1'b1; end
            if (j == 15) begin din_i[DW-1:0] = 12'h800; din_update_i[0] = 1'b1; end
            tick();
            din_update_i = '0;
        end
        lit("win1", 12'h800, 1'b1, 1'b1);
        cmp("win1_winend", 32'(win_end_o), 32'd1);

        run_window(4, 12'h020, -1, 12'h000);
        lit("win2", 12'h020, 1'b1, 1'b1);
        cmp("win2_winend", 32'(win_end_o), 32'd1);

        run_window(-1, 12'h000, -1, 12'h000);
        lit("empty_win", 12'h000, 1'b0, 1'b1);
        cmp("empty_winend", 32'(win_end_o), 32'd1);

        // clear in the middle of a window
        for (int j = 0; j < 7; j++) tick();
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        lit("midclr", 12'h000, 1'b0, 1'b0);
        cmp("midclr_winend", 32'(win_end_o), 32'd0);
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (win_end_o && first == 0) first = k;
        end
        cmp("clr_win_gap", 32'(first), 32'd16);

        // back to live tracking
        hold_en_i = 1'b0; mode_i = 2'b00;
        strobe(0, 12'h123); lit("live_last", 12'h123, 1'b1, 1'b1);
        tick();

        // async reset between edges
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        lit("async_rst", 12'h000, 1'b0, 1'b0);
        cmp("async_rst_winend", 32'(win_end_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        lit("post_rst", 12'h000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
